// File: rtl/iir_lpf_cfg_ctrl_if.sv
// Config bus and sample handshake between the CIC/iir_lpf datapath and iir_lpf_cfg_ctrl.
interface iir_lpf_cfg_ctrl_if;
    logic        cfg_wr;
    logic [2:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic        cfg_commit;
    logic        cfg_busy;
    logic        cfg_done;
    logic        req_in;
    logic        req_out;
    logic        y_new;
    logic        flt_srst;

    modport master (
        output cfg_wr, cfg_addr, cfg_wdata, cfg_commit, req_in, y_new,
        input  cfg_busy, cfg_done, req_out, flt_srst
    );

    modport slave (
        input  cfg_wr, cfg_addr, cfg_wdata, cfg_commit, req_in, y_new,
        output cfg_busy, cfg_done, req_out, flt_srst
    );
endinterface

// File: rtl/iir_lpf_cfg_ctrl.sv
// Coefficient bank sequencer for iir_lpf: shadow/active banks, drain -> flush -> settle switchover.
// Optional macro IIR_CFG_DROP_CNT_EN adds drop_cnt, a saturating count of requests blocked during switchover.
module iir_lpf_cfg_ctrl #(
    parameter int WLA            = 15,
    parameter int WLB            = 15,
    parameter int SETTLE_SAMPLES = 64,
    parameter int LAT_MAX        = 16,
    parameter int CNT_W          = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               srst,
    input  logic               enable,
    iir_lpf_cfg_ctrl_if.slave  lpf_if,
    output logic [WLA-1:0]     a1,
    output logic [WLA-1:0]     a2,
    output logic [WLB-1:0]     b0,
    output logic [WLB-1:0]     b1,
    output logic [WLB-1:0]     b2,
    output logic               settled,
    output logic               err_timeout
`ifdef IIR_CFG_DROP_CNT_EN
    ,
    output logic [CNT_W-1:0]   drop_cnt
`endif
);
    localparam int DW = $clog2(LAT_MAX) + 1;

    typedef enum logic [2:0] {IDLE, DRAIN, FLUSH1, FLUSH2, SETTLE} state_t;

    state_t           state, state_nxt;
    logic [WLA-1:0]   sh_a1, sh_a2;
    logic [WLB-1:0]   sh_b0, sh_b1, sh_b2;
    logic             in_flight, in_flight_nxt;
    logic [CNT_W-1:0] settle_cnt, settle_nxt;
    logic [DW-1:0]    drain_cnt, drain_nxt;
    logic             settled_nxt, err_nxt, load_active, done_c, start_sw;
    logic             wdata_unused;

    assign wdata_unused = ^lpf_if.cfg_wdata;

    assign start_sw        = enable & lpf_if.cfg_commit & (state == IDLE);
    assign lpf_if.req_out  = lpf_if.req_in & enable & ((state == IDLE) | (state == SETTLE));
    assign lpf_if.flt_srst = (state == FLUSH1) | (state == FLUSH2);
    assign lpf_if.cfg_busy = (state != IDLE);
    assign lpf_if.cfg_done = done_c;

    // Shadow bank accepts writes in every state, even while the block is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a1 <= '0; sh_a2 <= '0; sh_b0 <= '0; sh_b1 <= '0; sh_b2 <= '0;
        end else if (srst) begin
            sh_a1 <= '0; sh_a2 <= '0; sh_b0 <= '0; sh_b1 <= '0; sh_b2 <= '0;
        end else if (lpf_if.cfg_wr) begin
            case (lpf_if.cfg_addr)
                3'd0:    sh_a1 <= lpf_if.cfg_wdata[WLA-1:0];
                3'd1:    sh_a2 <= lpf_if.cfg_wdata[WLA-1:0];
                3'd2:    sh_b0 <= lpf_if.cfg_wdata[WLB-1:0];
                3'd3:    sh_b1 <= lpf_if.cfg_wdata[WLB-1:0];
                3'd4:    sh_b2 <= lpf_if.cfg_wdata[WLB-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt     = state;
        settle_nxt    = settle_cnt;
        drain_nxt     = drain_cnt;
        settled_nxt   = settled;
        err_nxt       = err_timeout;
        load_active   = 1'b0;
        done_c        = 1'b0;
        in_flight_nxt = in_flight;
        // A request issued in the same cycle as a returning y_new is a new sample in flight.
        if (lpf_if.req_out)
            in_flight_nxt = 1'b1;
        else if (enable && lpf_if.y_new)
            in_flight_nxt = 1'b0;
        if (enable) begin
            case (state)
                IDLE: if (lpf_if.cfg_commit) begin
                    state_nxt   = DRAIN;
                    drain_nxt   = '0;
                    settled_nxt = 1'b0;
                end
                DRAIN: if (!in_flight) begin
                    state_nxt = FLUSH1;
                end else if (drain_cnt == DW'(LAT_MAX - 1)) begin
                    state_nxt = FLUSH1;
                    err_nxt   = 1'b1;
                end else begin
                    drain_nxt = drain_cnt + DW'(1);
                end
                FLUSH1: begin
                    load_active = 1'b1;
                    state_nxt   = FLUSH2;
                end
                FLUSH2: begin
                    settle_nxt = '0;
                    state_nxt  = SETTLE;
                end
                SETTLE: if (lpf_if.y_new) begin
                    if (settle_cnt == CNT_W'(SETTLE_SAMPLES - 1)) begin
                        settled_nxt = 1'b1;
                        done_c      = 1'b1;
                        state_nxt   = IDLE;
                    end else begin
                        settle_nxt = settle_cnt + CNT_W'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE; in_flight <= 1'b0; settle_cnt <= '0; drain_cnt <= '0;
            settled <= 1'b0; err_timeout <= 1'b0;
            a1 <= '0; a2 <= '0; b0 <= '0; b1 <= '0; b2 <= '0;
        end else if (srst) begin
            state <= IDLE; in_flight <= 1'b0; settle_cnt <= '0; drain_cnt <= '0;
            settled <= 1'b0; err_timeout <= 1'b0;
            a1 <= '0; a2 <= '0; b0 <= '0; b1 <= '0; b2 <= '0;
        end else begin
            state       <= state_nxt;
            in_flight   <= in_flight_nxt;
            settle_cnt  <= settle_nxt;
            drain_cnt   <= drain_nxt;
            settled     <= settled_nxt;
            err_timeout <= err_nxt;
            if (load_active) begin
                a1 <= sh_a1; a2 <= sh_a2; b0 <= sh_b0; b1 <= sh_b1; b2 <= sh_b2;
            end
        end
    end

`ifdef IIR_CFG_DROP_CNT_EN
    logic drop_hit;
    assign drop_hit = enable & lpf_if.req_in &
                      ((state == DRAIN) | (state == FLUSH1) | (state == FLUSH2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_cnt <= '0;
        else if (srst || start_sw)
            drop_cnt <= '0;
        else if (drop_hit && (drop_cnt != '1))
            drop_cnt <= drop_cnt + CNT_W'(1);
    end
`endif
endmodule

// File: tb/tb_iir_lpf_cfg_ctrl.sv
// Directed bench for iir_lpf_cfg_ctrl: vector table for writes/request gating plus switchover sequences.
`timescale 1ns/1ps
module tb_iir_lpf_cfg_ctrl;
    logic        tb_clk = 1'b0;
    logic        rst_n, srst, enable;
    logic [14:0] a1, a2, b0, b1, b2;
    logic        settled, err_timeout;
`ifdef IIR_CFG_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    always #5 tb_clk = ~tb_clk;

    iir_lpf_cfg_ctrl_if bus ();

    iir_lpf_cfg_ctrl #(
        .WLA(15), .WLB(15), .SETTLE_SAMPLES(64), .LAT_MAX(16), .CNT_W(16)
    ) dut (
        .clk(tb_clk), .rst_n(rst_n), .srst(srst), .enable(enable), .lpf_if(bus),
        .a1(a1), .a2(a2), .b0(b0), .b1(b1), .b2(b2),
        .settled(settled), .err_timeout(err_timeout)
`ifdef IIR_CFG_DROP_CNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [15:0] wdata;
        logic        en;
        logic        req;
        logic        yn;
        logic        exp_req_out;
    } vec_t;

    vec_t        vt [8];
    logic [15:0] sh_m [5];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] addr, input logic [15:0] data);
        bus.cfg_wr = 1'b1; bus.cfg_addr = addr; bus.cfg_wdata = data;
        cyc();
        bus.cfg_wr = 1'b0;
        if (addr < 3'd5) sh_m[addr] = data & 16'h7fff;
    endtask

    task automatic chk_active(input string tag);
        chk({tag, "_a1"}, a1, sh_m[0]);
        chk({tag, "_a2"}, a2, sh_m[1]);
        chk({tag, "_b0"}, b0, sh_m[2]);
        chk({tag, "_b1"}, b1, sh_m[3]);
        chk({tag, "_b2"}, b2, sh_m[4]);
    endtask

    // Entered in the first SETTLE cycle; returns in IDLE after n y_new pulses.
    task automatic settle_run(input string tag, input int unsigned n, input logic req);
        for (int unsigned i = 0; i < n; i++) begin
            bus.y_new = 1'b1; bus.req_in = req;
            #1;
            chk({tag, "_req_out"}, bus.req_out, req);
            if (i == n - 1) begin
                chk({tag, "_done_pulse"}, bus.cfg_done, 1'b1);
            end else begin
                chk({tag, "_done_early"}, bus.cfg_done, 1'b0);
                chk({tag, "_settled_early"}, settled, 1'b0);
            end
            cyc();
        end
        bus.y_new = 1'b0; bus.req_in = 1'b0;
        #1;
        chk({tag, "_done_clear"}, bus.cfg_done, 1'b0);
        chk({tag, "_settled"}, settled, 1'b1);
        chk({tag, "_idle"}, bus.cfg_busy, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vt[0] = '{1'b1, 3'd0, 16'h48dc, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[1] = '{1'b1, 3'd1, 16'h188e, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[2] = '{1'b1, 3'd2, 16'h00b5, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[3] = '{1'b1, 3'd3, 16'h016a, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[4] = '{1'b1, 3'd4, 16'h00b5, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[5] = '{1'b1, 3'd6, 16'h7fff, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[6] = '{1'b1, 3'd7, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[7] = '{1'b1, 3'd5, 16'h2222, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) sh_m[i] = '0;

        rst_n = 1'b0; srst = 1'b0; enable = 1'b1;
        bus.cfg_wr = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0; bus.cfg_commit = 1'b0;
        bus.req_in = 1'b0; bus.y_new = 1'b0;
        cyc(); cyc();
        chk("rst_busy", bus.cfg_busy, 1'b0);
        chk("rst_flt_srst", bus.flt_srst, 1'b0);
        chk("rst_settled", settled, 1'b0);
        chk("rst_err", err_timeout, 1'b0);
        chk("rst_done", bus.cfg_done, 1'b0);
        chk_active("rst");
        rst_n = 1'b1;
        cyc();

        // Vector table: shadow writes, enable gating of req_out, in-flight bookkeeping.
        for (int i = 0; i < 8; i++) begin
            bus.cfg_wr = vt[i].wr; bus.cfg_addr = vt[i].addr; bus.cfg_wdata = vt[i].wdata;
            enable = vt[i].en; bus.req_in = vt[i].req; bus.y_new = vt[i].yn;
            #1;
            chk("vec_req_out", bus.req_out, vt[i].exp_req_out);
            chk("vec_busy", bus.cfg_busy, 1'b0);
            cyc();
            if (vt[i].wr && vt[i].addr < 3'd5) sh_m[vt[i].addr] = vt[i].wdata & 16'h7fff;
        end
        bus.cfg_wr = 1'b0; bus.req_in = 1'b0; bus.y_new = 1'b0; enable = 1'b1;
        chk("vec_active_a1_held", a1, 15'h0);

        // First switchover, no traffic: 1-cycle DRAIN, 2-cycle FLUSH, 64 samples to settle.
        bus.cfg_commit = 1'b1; #1;
        chk("t1_busy_pre", bus.cfg_busy, 1'b0);
        cyc(); bus.cfg_commit = 1'b0;
        chk("t1_drain_busy", bus.cfg_busy, 1'b1);
        chk("t1_drain_srst", bus.flt_srst, 1'b0);
        chk("t1_drain_settled", settled, 1'b0);
        cyc();
        chk("t1_flush1_srst", bus.flt_srst, 1'b1);
        chk("t1_flush1_a1_old", a1, 15'h0);
        cyc();
        chk("t1_flush2_srst", bus.flt_srst, 1'b1);
        chk_active("t1");
        cyc();
        chk("t1_settle_srst", bus.flt_srst, 1'b0);
        chk("t1_settle_busy", bus.cfg_busy, 1'b1);
        settle_run("t1", 64, 1'b0);
        chk("t1_err", err_timeout, 1'b0);

        // Commit one cycle after a request; filter answers 5 cycles after the request.
        wr(3'd0, 16'h1234);
        chk("t2_a1_held_idle", a1, 15'h48dc);
        bus.req_in = 1'b1; #1;
        chk("t2_req_out", bus.req_out, 1'b1);
        cyc(); bus.req_in = 1'b0;
        bus.cfg_commit = 1'b1;
        cyc(); bus.cfg_commit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t2_drain_srst", bus.flt_srst, 1'b0);
            chk("t2_drain_a1", a1, 15'h48dc);
            cyc();
        end
        bus.y_new = 1'b1; #1;
        chk("t2_drain_busy", bus.cfg_busy, 1'b1);
        cyc(); bus.y_new = 1'b0;
        chk("t2_drain_last", bus.flt_srst, 1'b0);
        cyc();
        chk("t2_flush1_srst", bus.flt_srst, 1'b1);
        chk("t2_flush1_a1", a1, 15'h48dc);
        chk("t2_err", err_timeout, 1'b0);
        cyc();
        chk_active("t2");
        cyc();

        // In SETTLE: write to addr 6, new a2, and a commit that must be ignored.
        wr(3'd6, 16'h5555);
        wr(3'd1, 16'h0abc);
        bus.cfg_commit = 1'b1;
        cyc(); bus.cfg_commit = 1'b0;
        chk("t5_busy", bus.cfg_busy, 1'b1);
        chk("t5_no_flush", bus.flt_srst, 1'b0);
        chk("t5_a2_held", a2, 15'h188e);
        cyc();
        chk("t5_no_flush2", bus.flt_srst, 1'b0);
        settle_run("t5", 64, 1'b0);
        chk("t5_a2_after", a2, 15'h188e);

        // Continuous requests from DRAIN on: blocked through DRAIN and FLUSH.
        bus.cfg_commit = 1'b1;
        cyc(); bus.cfg_commit = 1'b0; bus.req_in = 1'b1;
        #1;
        chk("t4_req_drain", bus.req_out, 1'b0);
        cyc();
        chk("t4_req_flush1", bus.req_out, 1'b0);
        chk("t4_flush1_srst", bus.flt_srst, 1'b1);
        cyc();
        chk("t4_req_flush2", bus.req_out, 1'b0);
        chk_active("t4");
        cyc();
        chk("t4_req_settle", bus.req_out, 1'b1);
`ifdef IIR_CFG_DROP_CNT_EN
        chk("t4_drop_cnt", drop_cnt, 16'd3);
`endif
        settle_run("t4", 64, 1'b1);
`ifdef IIR_CFG_DROP_CNT_EN
        chk("t4_drop_cnt_hold", drop_cnt, 16'd3);
`endif

        // Stub filter never answers: DRAIN times out after 16 cycles.
        bus.req_in = 1'b1;
        cyc(); bus.req_in = 1'b0;
        bus.cfg_commit = 1'b1;
        cyc(); bus.cfg_commit = 1'b0;
`ifdef IIR_CFG_DROP_CNT_EN
        chk("t3_drop_cleared", drop_cnt, 16'd0);
`endif
        for (int i = 1; i <= 16; i++) begin
            chk("t3_drain_srst", bus.flt_srst, 1'b0);
            chk("t3_drain_err", err_timeout, 1'b0);
            cyc();
        end
        chk("t3_flush_entry", bus.flt_srst, 1'b1);
        chk("t3_err_set", err_timeout, 1'b1);
        cyc();
        chk_active("t3");
        cyc();
        settle_run("t3", 64, 1'b0);
        chk("t3_err_sticky", err_timeout, 1'b1);

        // Freeze in FLUSH with enable low, then async reset mid-FLUSH.
        wr(3'd2, 16'h0042);
        bus.cfg_commit = 1'b1;
        cyc(); bus.cfg_commit = 1'b0;
        cyc();
        chk("t6_flush1_srst", bus.flt_srst, 1'b1);
        enable = 1'b0; bus.req_in = 1'b1; #1;
        chk("t6_frozen_req", bus.req_out, 1'b0);
        cyc(); cyc();
        chk("t6_frozen_srst", bus.flt_srst, 1'b1);
        chk("t6_frozen_b0", b0, 15'h00b5);
        enable = 1'b1; bus.req_in = 1'b0;
        cyc();
        chk_active("t6");
        chk("t6_flush2_srst", bus.flt_srst, 1'b1);
        #2; rst_n = 1'b0; #1;
        chk("t6_rst_srst", bus.flt_srst, 1'b0);
        chk("t6_rst_busy", bus.cfg_busy, 1'b0);
        chk("t6_rst_err", err_timeout, 1'b0);
        chk("t6_rst_settled", settled, 1'b0);
        for (int i = 0; i < 5; i++) sh_m[i] = '0;
        chk_active("t6_rst");
        cyc(); rst_n = 1'b1;
        cyc();

        // Synchronous reset: beats a same-cycle commit, and aborts a FLUSH before the bank load.
        wr(3'd0, 16'h0777);
        bus.cfg_commit = 1'b1; srst = 1'b1;
        cyc(); bus.cfg_commit = 1'b0; srst = 1'b0;
        chk("srst_beats_commit", bus.cfg_busy, 1'b0);
        wr(3'd0, 16'h0777);
        bus.cfg_commit = 1'b1;
        cyc(); bus.cfg_commit = 1'b0;
        cyc();
        srst = 1'b1; #1;
        chk("srst_flush_pre", bus.flt_srst, 1'b1);
        cyc(); srst = 1'b0;
        chk("srst_flush_srst", bus.flt_srst, 1'b0);
        chk("srst_flush_busy", bus.cfg_busy, 1'b0);
        chk("srst_flush_a1", a1, 15'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/iir_lpf_cfg_ctrl.md
Name: iir_lpf_cfg_ctrl

Overview:
Configuration sequencer for the biquad IIR low-pass filter (iir_lpf) fed by the CIC decimator.
- Holds shadow and active coefficient banks (a1, a2, b0, b1, b2).
- Switches banks only when the filter has no sample in flight, then flushes the filter state with a synchronous reset.
- Counts output samples until the configured settling window has elapsed, then reports settled.
- Sits between the CIC request/data path and iir_lpf: gates req and drives the coefficient and srst inputs.

Parameters:
- WLA, 15, a-coefficient word length (format 1,WLA,WLA-2).
- WLB, 15, b-coefficient word length (format 1,WLB,WLB-1).
- SETTLE_SAMPLES, 64, number of y_new pulses after a flush before settled asserts (>=1).
- LAT_MAX, 16, maximum cycles in DRAIN before a forced flush.
- CNT_W, 16, width of the settle and drop counters.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- srst  in  1  synchronous reset, active high
- enable  in  1  block enable; 0 freezes FSM and counters
- cfg_wr  in  1  shadow register write strobe
- cfg_addr  in  3  0=a1 1=a2 2=b0 3=b1 4=b2; 5..7 ignored
- cfg_wdata  in  16  write data, LSB-aligned
- cfg_commit  in  1  request shadow->active switchover (pulse)
- cfg_busy  out  1  high in any state other than IDLE
- cfg_done  out  1  one-cycle pulse when settled rises
- req_in  in  1  sample request from the CIC model
- req_out  out  1  gated request to iir_lpf.req
- y_new  in  1  iir_lpf.y_new
- flt_srst  out  1  to iir_lpf.srst
- a1, a2  out  WLA  active a coefficients
- b0, b1, b2  out  WLB  active b coefficients
- settled  out  1  filter output valid for the current coefficients
- err_timeout  out  1  sticky: DRAIN exited by timeout

Behaviour:
- Reset (rst_n low async, or srst high sync): all shadow/active coefficients 0, FSM=IDLE, flt_srst=0, settled=0, cfg_busy=0, cfg_done=0, err_timeout=0, counters 0, in-flight flag 0.
- enable=0: all state holds, req_out=0, flt_srst holds. Shadow writes are still accepted.
- Shadow write: cfg_wr=1 with addr 0..4 loads cfg_wdata[WLA-1:0] or cfg_wdata[WLB-1:0] at the clock edge, in any state. Addresses 5..7 are no-ops.
- In-flight flag: set on the cycle req_out=1; cleared on y_new=1. If both occur in the same cycle, the flag stays set.
- req_out = req_in & enable & (state==IDLE | state==SETTLE). It is combinational, with zero added latency.
- FSM:
  - IDLE: on cfg_commit -> DRAIN. settled holds.
  - DRAIN: settled=0, requests blocked.
    - Exit when in-flight==0 -> FLUSH.
    - Also exit after LAT_MAX cycles in DRAIN -> FLUSH, setting err_timeout.
  - FLUSH (exactly 2 cycles): flt_srst=1 both cycles. On the first cycle, active<=shadow (all five at once). Then -> SETTLE with settle_cnt=0.
  - SETTLE: each y_new increments settle_cnt. When settle_cnt reaches SETTLE_SAMPLES-1 and y_new=1: settled<=1, cfg_done pulses that cycle, -> IDLE.
- cfg_commit outside IDLE is ignored; no queueing.
- cfg_commit in the same cycle as srst: srst wins.
- Active coefficients never change outside FLUSH, so iir_lpf sees glitch-free coefficients across a sample.
- Reset mid-FLUSH: flt_srst drops immediately (async) or next edge (srst), and active returns to 0.

Optional Feature:
- Macro IIR_CFG_DROP_CNT_EN.
- When defined: adds output drop_cnt [CNT_W-1:0]. It increments (saturating at all-ones) for every req_in=1 & enable=1 blocked in DRAIN/FLUSH. It clears on reset and on the cfg_commit that starts a new switchover.
- When undefined: the port and its logic are absent, and dropped requests are silent.

Test Plan:
- After reset: write a1=0x48dc, a2=0x188e, b0=0x00b5, b1=0x016a, b2=0x00b5, then commit while idle with no traffic.
  -> DRAIN lasts 1 cycle, flt_srst high 2 cycles, outputs equal the written values, settled=0.
  -> settled=1 and cfg_done one-cycle pulse on the 64th y_new.
- Commit one cycle after req_out with the filter latency at 5 cycles.
  -> Stays in DRAIN until y_new; active coefficients are unchanged until FLUSH; err_timeout=0.
- Commit with a stub filter that never returns y_new.
  -> FLUSH entered after exactly 16 DRAIN cycles; err_timeout=1 and stays 1 until reset.
- Continuous 0.5 step stimulus with req_in every cycle.
  -> req_out=0 throughout DRAIN and FLUSH.
  -> With IIR_CFG_DROP_CNT_EN defined: drop_cnt equals the number of blocked requests (e.g. 3 for a 1-cycle DRAIN plus 2-cycle FLUSH).
- Second commit during SETTLE and a write to addr 6.
  -> Commit ignored, cfg_busy stays 1, no shadow change; a later commit applies the newer shadow values.
- rst_n pulse during FLUSH.
  -> All outputs at reset values within the same cycle, FSM=IDLE, a1..b2=0.
